// File: rtl/soc_dma_pkg.sv
// Shared definitions for the single-channel word-copy DMA engine.
//   dma_state_t     : engine states (IDLE, READ, WRITE, FINISH)
//   DMA_WORD_BYTES  : byte stride between consecutive words
//   DMA_FULL_STROBE : byte-enable pattern used on every write
//   dma_word_align  : clears the byte-offset bits of an address
package soc_dma_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    WRITE  = 2'd2,
    FINISH = 2'd3
  } dma_state_t;

  localparam int unsigned DMA_WORD_BYTES  = 4;
  localparam logic [3:0]  DMA_FULL_STROBE = 4'b1111;

  // The engine only moves whole words, so any byte offset supplied by
  // software is dropped rather than flagged.
  function automatic logic [31:0] dma_word_align(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/soc_dma_engine.sv
// Single-channel word-copy DMA master for the SoC memory bus.
// Copies `len` 32-bit words from src_addr to dst_addr in strictly ascending
// order, one read followed by one write per word.
//
// Ports:
//   clk, resn            : clock, asynchronous active-low reset
//   start, abort         : single-cycle control pulses from the SoC controller
//   src_addr, dst_addr   : byte addresses (bits [1:0] ignored)
//   len                  : number of words to copy
//   busy                 : transfer in progress
//   done_irq             : one-cycle pulse on completion or abort
//   aborted              : last transfer ended by abort
//   words_done           : words written in the current/last transfer
//   mem_req/we/addr/wdata/wstrb : bus master request side
//   mem_ready, mem_rdata : bus slave response side
module soc_dma_engine
  import soc_dma_pkg::*;
#(
  parameter int LEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 resn,
  input  logic                 start,
  input  logic                 abort,
  input  logic [31:0]          src_addr,
  input  logic [31:0]          dst_addr,
  input  logic [LEN_WIDTH-1:0] len,
  output logic                 busy,
  output logic                 done_irq,
  output logic                 aborted,
  output logic [LEN_WIDTH-1:0] words_done,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [31:0]          mem_addr,
  output logic [31:0]          mem_wdata,
  output logic [3:0]           mem_wstrb,
  input  logic                 mem_ready,
  input  logic [31:0]          mem_rdata
);

  localparam logic [LEN_WIDTH-1:0] LEN_ZERO = '0;
  localparam logic [LEN_WIDTH-1:0] LEN_ONE  = LEN_WIDTH'(1);

  dma_state_t           state_reg;
  dma_state_t           state_next;
  logic [31:0]          src_reg;
  logic [31:0]          dst_reg;
  logic [LEN_WIDTH-1:0] remaining_reg;
  logic [LEN_WIDTH-1:0] words_done_reg;
  logic [31:0]          buffer_reg;
  logic                 aborted_reg;
  logic                 abort_pending_reg;

  // An abort arriving in the completion cycle itself must still stop the
  // engine at the end of that access, so the live input is merged with the
  // stored flag when deciding where to go next.
  logic abort_seen;
  assign abort_seen = abort_pending_reg | abort;

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = (len == LEN_ZERO) ? FINISH : READ;
        end
      end
      READ: begin
        if (mem_ready) begin
          state_next = abort_seen ? FINISH : WRITE;
        end
      end
      WRITE: begin
        if (mem_ready) begin
          state_next = ((remaining_reg == LEN_ONE) || abort_seen) ? FINISH : READ;
        end
      end
      FINISH: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath: pointers, counters, data buffer and abort bookkeeping
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      src_reg           <= '0;
      dst_reg           <= '0;
      remaining_reg     <= '0;
      words_done_reg    <= '0;
      buffer_reg        <= '0;
      aborted_reg       <= 1'b0;
      abort_pending_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            src_reg           <= dma_word_align(src_addr);
            dst_reg           <= dma_word_align(dst_addr);
            remaining_reg     <= len;
            words_done_reg    <= '0;
            aborted_reg       <= 1'b0;
            abort_pending_reg <= 1'b0;
          end
        end
        READ: begin
          abort_pending_reg <= abort_seen;
          if (mem_ready) begin
            buffer_reg <= mem_rdata;
            src_reg    <= src_reg + DMA_WORD_BYTES;
            if (abort_seen) begin
              aborted_reg <= 1'b1;
            end
          end
        end
        WRITE: begin
          abort_pending_reg <= abort_seen;
          if (mem_ready) begin
            dst_reg        <= dst_reg + DMA_WORD_BYTES;
            remaining_reg  <= remaining_reg - LEN_ONE;
            words_done_reg <= words_done_reg + LEN_ONE;
            if (abort_seen) begin
              aborted_reg <= 1'b1;
            end
          end
        end
        FINISH: begin
          abort_pending_reg <= 1'b0;
        end
        default: begin
          abort_pending_reg <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Outputs: decoded from state and registers only, so nothing on the
  // response side (mem_ready/mem_rdata) reaches the request side
  // combinationally and the request stays frozen during wait states.
  // ---------------------------------------------------------------------
  always_comb begin
    busy      = 1'b0;
    done_irq  = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 32'h0;
    mem_wstrb = 4'b0000;
    case (state_reg)
      READ: begin
        busy     = 1'b1;
        mem_req  = 1'b1;
        mem_addr = src_reg;
      end
      WRITE: begin
        busy      = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = dst_reg;
        mem_wstrb = DMA_FULL_STROBE;
      end
      FINISH: begin
        busy     = 1'b1;
        done_irq = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign mem_wdata  = buffer_reg;
  assign aborted    = aborted_reg;
  assign words_done = words_done_reg;

endmodule

// File: tb/tb_soc_dma_engine.sv
module tb_soc_dma_engine;

  logic        clk;
  logic        resn;
  logic        start;
  logic        abort;
  logic [31:0] src_addr;
  logic [31:0] dst_addr;
  logic [15:0] len;
  logic        busy;
  logic        done_irq;
  logic        aborted;
  logic [15:0] words_done;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  soc_dma_engine #(.LEN_WIDTH(16)) dut (
    .clk        (clk),
    .resn       (resn),
    .start      (start),
    .abort      (abort),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .len        (len),
    .busy       (busy),
    .done_irq   (done_irq),
    .aborted    (aborted),
    .words_done (words_done),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Slave RAM (what the bus talks to) and model RAM (what the copy should do)
  logic [31:0] ram       [logic [31:0]];
  logic [31:0] model_ram [logic [31:0]];

  function automatic logic [31:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : 32'h0;
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    return model_ram.exists(a) ? model_ram[a] : 32'h0;
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    ram[a]       = d;
    model_ram[a] = d;
  endtask

  // Model: expected bus transactions of the current transfer, in order
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
  } tx_t;
  tx_t         exp_q[$];
  logic [31:0] log_q[$];
  int          tx_count    = 0;
  int          model_words = 0;
  logic [31:0] last_rd     = 32'h0;
  int          done_count  = 0;
  int          last_done_cyc = -1;
  int          start_cyc   = 0;
  int          waits       = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bus slave with a programmable number of wait states per access
  int wcnt = 0;
  initial begin
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (resn && mem_req && wcnt == waits) begin
        mem_ready = 1'b1;
        mem_rdata = mem_we ? 32'h0 : ram_rd(mem_addr);
      end else begin
        mem_ready = 1'b0;
      end
      @(negedge clk);
      if (!resn) begin
        wcnt = 0;
      end else if (mem_req && mem_ready) begin
        if (mem_we) ram[mem_addr] = mem_wdata;
        wcnt = 0;
      end else if (mem_req) begin
        wcnt++;
      end
    end
  end

  // Compare process: checks DUT outputs against the model every cycle
  logic        prev_stall = 1'b0;
  logic        prev_we;
  logic [31:0] prev_addr;
  logic [31:0] prev_wdata;
  logic [3:0]  prev_wstrb;
  initial begin
    forever begin
      @(negedge clk);
      if (!resn) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("stall_req",   mem_req,   1'b1);
          chk("stall_we",    mem_we,    prev_we);
          chk("stall_addr",  mem_addr,  prev_addr);
          chk("stall_wdata", mem_wdata, prev_wdata);
          chk("stall_wstrb", mem_wstrb, prev_wstrb);
        end
        if (mem_req) begin
          chk("req_busy", busy, 1'b1);
          chk("wstrb", mem_wstrb, mem_we ? 4'hF : 4'h0);
        end
        if (done_irq) begin
          chk("done_busy", busy, 1'b1);
          done_count++;
          last_done_cyc = cyc - start_cyc;
        end
        if (busy) chk("words_done_track", words_done, model_words);
        if (mem_req && mem_ready) begin
          tx_count++;
          log_q.push_back(mem_addr);
          $display("tx %0d we=%0d addr=%h wdata=%h rdata=%h", tx_count, mem_we, mem_addr,
                   mem_wdata, mem_rdata);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_tx actual addr=%h expected none", mem_addr);
          end else begin
            tx_t e;
            e = exp_q.pop_front();
            chk("tx_we",   mem_we,   e.we);
            chk("tx_addr", mem_addr, e.addr);
            if (e.we) begin
              chk("tx_wdata", mem_wdata, model_rd(last_rd));
              model_ram[e.addr] = model_rd(last_rd);
              model_words++;
            end else begin
              last_rd = e.addr;
            end
          end
        end
        prev_stall = mem_req && !mem_ready;
        prev_we    = mem_we;
        prev_addr  = mem_addr;
        prev_wdata = mem_wdata;
        prev_wstrb = mem_wstrb;
      end
    end
  end

  task automatic build_model(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
    exp_q.delete();
    log_q.delete();
    tx_count    = 0;
    model_words = 0;
    for (int k = 0; k < int'(n); k++) begin
      exp_q.push_back({1'b0, (s & ~32'h3) + 32'(4 * k)});
      exp_q.push_back({1'b1, (d & ~32'h3) + 32'(4 * k)});
    end
  endtask

  // Runs one transfer; abort_at / start_at give cycles (relative to start)
  // in which a stray abort or a second start (with len 7) is pulsed.
  task automatic run_xfer(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                          input int w, input int abort_at, input int start_at, output int dcyc);
    int seen;
    waits = w;
    build_model(s, d, n);
    tick();
    src_addr  = s;
    dst_addr  = d;
    len       = n;
    start     = 1'b1;
    start_cyc = cyc;
    seen      = done_count;
    dcyc      = -1;
    for (int c = 1; c <= 300 && dcyc < 0; c++) begin
      tick();
      start = 1'b0;
      abort = 1'b0;
      if (c == abort_at) abort = 1'b1;
      if (c == start_at) begin
        start = 1'b1;
        len   = 16'd7;
      end
      if (done_count != seen) dcyc = last_done_cyc;
    end
    start = 1'b0;
    abort = 1'b0;
    if (dcyc < 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=none expected=done_irq within 300 cycles");
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_busy"},       busy,       1'b0);
    chk({tag, "_done_irq"},   done_irq,   1'b0);
    chk({tag, "_aborted"},    aborted,    1'b0);
    chk({tag, "_mem_req"},    mem_req,    1'b0);
    chk({tag, "_mem_we"},     mem_we,     1'b0);
    chk({tag, "_words_done"}, words_done, 16'h0);
    chk({tag, "_mem_addr"},   mem_addr,   32'h0);
    chk({tag, "_mem_wdata"},  mem_wdata,  32'h0);
    chk({tag, "_mem_wstrb"},  mem_wstrb,  4'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=still running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc;
    int dn;
    resn     = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    src_addr = 32'h0;
    dst_addr = 32'h0;
    len      = 16'h0;
    repeat (3) tick();
    chk_reset_values("reset");
    resn = 1'b1;
    tick();
    // abort while idle must have no effect
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("idle_abort_busy", busy, 1'b0);

    // Zero-wait copy, with a start pulsed in the FINISH cycle (cycle 9)
    for (int k = 0; k < 4; k++) preload(32'h1000 + 32'(4 * k), 32'hA000_0000 + 32'(k));
    run_xfer(32'h1000, 32'h2000, 16'd4, 0, 0, 9, dc);
    chk("zw_done_cycle", 32'(dc), 32'd9);
    chk("zw_busy_after", busy, 1'b0);
    chk("zw_tx_count", 32'(tx_count), 32'd8);
    chk("zw_words_done", words_done, 16'd4);
    chk("zw_aborted", aborted, 1'b0);
    chk("zw_dst0", ram_rd(32'h2000), 32'hA000_0000);
    chk("zw_dst1", ram_rd(32'h2004), 32'hA000_0001);
    chk("zw_dst2", ram_rd(32'h2008), 32'hA000_0002);
    chk("zw_dst3", ram_rd(32'h200C), 32'hA000_0003);
    repeat (3) tick();
    chk("zw_finish_start_ignored", busy, 1'b0);

    // Three wait states per access
    preload(32'h3000, 32'h1234_5678);
    preload(32'h3004, 32'h9ABC_DEF0);
    run_xfer(32'h3000, 32'h4000, 16'd2, 3, 0, 0, dc);
    chk("ws_done_cycle", 32'(dc), 32'd17);
    chk("ws_tx_count", 32'(tx_count), 32'd4);
    chk("ws_dst0", ram_rd(32'h4000), 32'h1234_5678);
    chk("ws_dst1", ram_rd(32'h4004), 32'h9ABC_DEF0);

    // Zero length
    run_xfer(32'h5000, 32'h5100, 16'd0, 0, 0, 0, dc);
    chk("zl_done_cycle", 32'(dc), 32'd1);
    chk("zl_tx_count", 32'(tx_count), 32'd0);
    chk("zl_words_done", words_done, 16'd0);

    // Abort during the second READ while it is stalled
    for (int k = 0; k < 8; k++) preload(32'h6000 + 32'(4 * k), 32'hC0DE_0000 + 32'(k));
    dn = done_count;
    run_xfer(32'h6000, 32'h6800, 16'd8, 2, 7, 0, dc);
    repeat (5) tick();
    chk("ab_done_cycle", 32'(dc), 32'd10);
    chk("ab_tx_count", 32'(tx_count), 32'd3);
    chk("ab_aborted", aborted, 1'b1);
    chk("ab_words_done", words_done, 16'd1);
    chk("ab_done_pulses", 32'(done_count - dn), 32'd1);
    chk("ab_dst0", ram_rd(32'h6800), 32'hC0DE_0000);
    chk("ab_no_dst1", ram_rd(32'h6804), 32'h0);

    // Address wrap and alignment
    preload(32'hFFFF_FFFC, 32'h1111_1111);
    preload(32'h0000_0000, 32'h2222_2222);
    run_xfer(32'hFFFF_FFFE, 32'h0000_0100, 16'd2, 0, 0, 0, dc);
    chk("wr_done_cycle", 32'(dc), 32'd5);
    chk("wr_aborted_cleared", aborted, 1'b0);
    chk("wr_rd0_addr", (log_q.size() > 0) ? log_q[0] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
    chk("wr_rd1_addr", (log_q.size() > 2) ? log_q[2] : 32'hDEAD_BEEF, 32'h0000_0000);
    chk("wr_dst0", ram_rd(32'h100), 32'h1111_1111);
    chk("wr_dst1", ram_rd(32'h104), 32'h2222_2222);

    // Reset during a WRITE stall
    waits = 3;
    exp_q.delete();
    exp_q.push_back({1'b0, 32'h1000});
    exp_q.push_back({1'b1, 32'h7000});
    model_words = 0;
    tick();
    src_addr  = 32'h1000;
    dst_addr  = 32'h7000;
    len       = 16'd4;
    start     = 1'b1;
    start_cyc = cyc;
    for (int c = 1; c <= 6; c++) begin
      tick();
      start = 1'b0;
    end
    chk("rs_in_write_req", mem_req, 1'b1);
    chk("rs_in_write_we", mem_we, 1'b1);
    resn = 1'b0;
    #1;
    chk_reset_values("rs");
    tick();
    tick();
    resn = 1'b1;
    chk("rs_no_write", ram_rd(32'h7000), 32'h0);

    // After reset: start pulsed while busy (cycle 2, len 7) is ignored
    run_xfer(32'h1000, 32'h8000, 16'd3, 0, 0, 2, dc);
    chk("ig_done_cycle", 32'(dc), 32'd7);
    chk("ig_words_done", words_done, 16'd3);
    chk("ig_tx_count", 32'(tx_count), 32'd6);
    chk("ig_dst2", ram_rd(32'h8008), 32'hA000_0002);
    repeat (3) tick();
    chk("ig_idle_after", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/soc_dma_engine.md
# soc_dma_engine

Single-channel word-copy DMA engine acting as an additional master on the SoC memory bus interconnect, alongside the instruction, data and UART-bridge masters. It copies a block of 32-bit words from a source address range to a destination address range by issuing the read/write transactions that slave blocks (RAM, framebuffer, peripherals) respond to. Configuration and start come from the peripheral controller. Completion is signalled as a one-cycle pulse routed into `core_int_triggers`.

## Interface
- `LEN_WIDTH`, 16: width of the word-count input and progress counter.
- `clk`  in  1: main SoC clock (`main_clk`).
- `resn`  in  1: asynchronous, active-low reset.
- `start`  in  1: single-cycle start request; honoured only in IDLE.
- `abort`  in  1: single-cycle abort request; honoured only while busy.
- `src_addr`  in  32: source byte address; bits [1:0] ignored (treated as 0).
- `dst_addr`  in  32: destination byte address; bits [1:0] ignored.
- `len`  in  LEN_WIDTH: number of words to copy.
- `busy`  out  1: transfer in progress.
- `done_irq`  out  1: one-cycle pulse on completion or abort.
- `aborted`  out  1: last transfer ended by abort; cleared on next accepted start.
- `words_done`  out  LEN_WIDTH: words written so far in the current/last transfer.
- `mem_req`  out  1: bus request, master side.
- `mem_we`  out  1: 1 = write, 0 = read.
- `mem_addr`  out  32: word-aligned byte address.
- `mem_wdata`  out  32: write data.
- `mem_wstrb`  out  4: byte strobes; always 4'b1111 on writes, 4'b0000 on reads.
- `mem_ready`  in  1: slave completion; the transfer completes in the cycle where `mem_req` && `mem_ready`.
- `mem_rdata`  in  32: read data; valid in the read completion cycle.

## Operation
- States: IDLE, READ, WRITE, FINISH.
- IDLE: on `start`, do the following:
  - latch `src_addr` and `dst_addr` with bits [1:0] cleared, and latch `len` into `remaining`;
  - clear `words_done` and `aborted`.
  - If `len` == 0, go to FINISH. Otherwise go to READ.
- READ: hold `mem_req`=1, `mem_we`=0, `mem_addr`=current source.
  - On `mem_ready`: capture `mem_rdata` into the data buffer and advance source by 4.
  - Then go to FINISH if an abort is pending, else to WRITE.
- WRITE: hold `mem_req`=1, `mem_we`=1, `mem_addr`=current destination, `mem_wdata`=buffer.
  - On `mem_ready`: advance destination by 4, decrement `remaining` and increment `words_done`.
  - Then go to FINISH if `remaining` was 1 or an abort is pending; otherwise go to READ.
- FINISH: assert `done_irq` for exactly this cycle, then go to IDLE.
- Request stability: while `mem_req` is high and `mem_ready` is low, all `mem_*` outputs stay constant. A request is never withdrawn before it completes.
- Abort handling:
  - `abort` in READ or WRITE sets an abort-pending flag. The current transaction always completes before the engine leaves that state.
  - `abort` arriving in the same cycle as `mem_ready` counts as pending for that completion.
  - On reaching FINISH with abort pending, `aborted` is set to 1.
  - `abort` in IDLE or FINISH is ignored.
- `start` outside IDLE is ignored, including a `start` in the same cycle as FINISH.
- Address arithmetic: addresses advance by 4 modulo 2^32. Wrap past 0xFFFFFFFC goes to 0x00000000 with no error.
- Overlapping source and destination ranges: copying is strictly ascending, word by word. No overlap correction.
- `busy` = (state != IDLE).

## Timing
- Reset values:
  - state IDLE;
  - `busy`, `done_irq`, `aborted`, `mem_req`, `mem_we` all 0;
  - `words_done`, `mem_addr`, `mem_wdata`, `mem_wstrb` all 0.
- Reset asserted mid-transfer drops `mem_req` immediately. The interconnect is reset by the same source.
- Start latency: `start` sampled in cycle 0 gives `busy`=1 and the first READ request in cycle 1.
- Throughput: 2 cycles per word when slaves answer with zero wait states. Each wait state adds one cycle.
- `done_irq` is asserted in the cycle after the last write completes. `busy` is 0 from the following cycle.
- `len`=0: FINISH in cycle 1, `done_irq` in cycle 1, no bus activity.
- All outputs are registered or decoded directly from state registers. There is no combinational path from `mem_ready` or `mem_rdata` to any `mem_*` output.

## Structure
- Shared package `soc_dma_pkg`:
  - state enum `dma_state_t` (IDLE, READ, WRITE, FINISH);
  - constant `DMA_WORD_BYTES` = 4;
  - constant `DMA_FULL_STROBE` = 4'b1111.
- Top level: add the engine to the interconnect's master list, and add the `start`/`src`/`dst`/`len` registers to the SoC controller.
- Single flat module. No sub-module is warranted.

## Test plan
- Zero-wait copy: src 0x1000, dst 0x2000, len 4, RAM with 0 wait states.
  - Expect 8 bus transactions alternating read/write and `words_done`=4.
  - Expect `done_irq` in cycle 9 after start, and destination contents equal to source.
- Wait states: slave holds `mem_ready` low for 3 cycles per access, len 2.
  - Expect `mem_addr`, `mem_we` and `mem_wdata` unchanged throughout every stall, and completion at cycle 17.
- Zero length: `len`=0.
  - Expect `done_irq` in cycle 1, `mem_req` never asserted, `words_done`=0.
- Mid-transfer abort: `abort` asserted in the second READ while `mem_ready` is low, len 8.
  - Expect that read to complete and no further write.
  - Expect `aborted`=1, `words_done`=1, and a single `done_irq`.
- Address wrap and alignment: src 0xFFFFFFFE, len 2.
  - Expect reads at 0xFFFFFFFC and then 0x00000000.
- Reset and ignored start: assert `resn`=0 during a WRITE stall.
  - Expect `mem_req` low immediately and all outputs at reset values.
  - After release, a `start` pulsed while busy is ignored and does not change the latched `len`.
